// File: rtl/instruction_fetch_queue_if.sv
// instruction_fetch_queue_if: ICache, predictor, flush, JALR and dispatch signals of the fetch queue.
interface instruction_fetch_queue_if #(parameter int PTR_W = 3);
   logic ic_rdy;
   logic [31:0] ins;
   logic ins_asked;
   logic [31:0] ins_addr;
   logic ask_predictor;
   logic [31:0] ask_ins_addr;
   logic [31:0] jump_addr;
   logic [31:0] next_addr;
   logic jump;
   logic predictor_sgn_rdy;
   logic predictor_full;
   logic if_flush;
   logic [31:0] addr_from_predictor;
   logic jalr_commit;
   logic [31:0] jalr_addr;
   logic rob_full;
   logic lsb_full;
   logic if_ins_launch_flag;
   logic [31:0] if_ins;
   logic [31:0] if_ins_pc;
   logic [PTR_W:0] queue_count;
   modport master (
      input ic_rdy, ins, jump, predictor_sgn_rdy, predictor_full, if_flush, addr_from_predictor,
            jalr_commit, jalr_addr, rob_full, lsb_full,
      output ins_asked, ins_addr, ask_predictor, ask_ins_addr, jump_addr, next_addr,
             if_ins_launch_flag, if_ins, if_ins_pc, queue_count
   );
   modport slave (
      output ic_rdy, ins, jump, predictor_sgn_rdy, predictor_full, if_flush, addr_from_predictor,
             jalr_commit, jalr_addr, rob_full, lsb_full,
      input ins_asked, ins_addr, ask_predictor, ask_ins_addr, jump_addr, next_addr,
            if_ins_launch_flag, if_ins, if_ins_pc, queue_count
   );
endinterface

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: fetch FSM with next-PC decode feeding a launch FIFO toward issue.
module instruction_fetch_queue #(
   parameter int QUEUE_DEPTH = 8,
   parameter int PTR_W = 3,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic clk,
   input logic rst,
   input logic rdy,
   instruction_fetch_queue_if.master bus
);
   typedef enum logic [2:0] {IDLE, WAIT_INS, PREDICT, WAIT_PRED, JALR_HOLD, DRAIN} state_t;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   state_t state, state_n;
   logic [31:0] pc, pc_n, ins_q, ins_q_n, enq_ins;
   logic [31:0] ins_addr_n, ask_ins_addr_n, jump_addr_n, next_addr_n;
   logic [31:0] j_imm, b_imm;
   logic ask_n, pred_n, enq, pop;
   logic [31:0] mem_ins [QUEUE_DEPTH];
   logic [31:0] mem_pc [QUEUE_DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [PTR_W:0] count;
   assign j_imm = {{11{bus.ins[31]}}, bus.ins[31], bus.ins[19:12], bus.ins[20], bus.ins[30:21], 1'b0};
   assign b_imm = {{19{ins_q[31]}}, ins_q[31], ins_q[7], ins_q[30:25], ins_q[11:8], 1'b0};
   assign pop = count != '0 && !bus.rob_full && !bus.lsb_full && !bus.if_flush;
   assign bus.queue_count = count;
   always_comb begin
      state_n = state;
      pc_n = pc;
      ins_q_n = ins_q;
      enq_ins = bus.ins;
      ins_addr_n = bus.ins_addr;
      ask_ins_addr_n = bus.ask_ins_addr;
      jump_addr_n = bus.jump_addr;
      next_addr_n = bus.next_addr;
      ask_n = 1'b0;
      pred_n = 1'b0;
      enq = 1'b0;
      case (state)
         IDLE: if (count < (PTR_W+1)'(QUEUE_DEPTH)) begin
            ask_n = 1'b1;
            ins_addr_n = pc;
            state_n = WAIT_INS;
         end
         WAIT_INS: if (bus.ic_rdy) begin
            ins_q_n = bus.ins;
            enq = bus.ins[6:0] != OP_BRANCH;
            state_n = bus.ins[6:0] == OP_BRANCH ? PREDICT : bus.ins[6:0] == OP_JALR ? JALR_HOLD : IDLE;
            pc_n = bus.ins[6:0] == OP_JAL ? pc + j_imm : bus.ins[6:0] == OP_BRANCH || bus.ins[6:0] == OP_JALR ? pc : pc + 32'd4;
         end
         PREDICT: if (!bus.predictor_full) begin
            pred_n = 1'b1;
            ask_ins_addr_n = pc;
            jump_addr_n = pc + b_imm;
            next_addr_n = pc + 32'd4;
            state_n = WAIT_PRED;
         end
         WAIT_PRED: if (bus.predictor_sgn_rdy) begin
            enq = 1'b1;
            enq_ins = ins_q;
            pc_n = bus.jump ? bus.jump_addr : bus.next_addr;
            state_n = IDLE;
         end
         JALR_HOLD: if (bus.jalr_commit) begin
            pc_n = bus.jalr_addr;
            state_n = IDLE;
         end
         DRAIN: state_n = bus.ic_rdy ? IDLE : DRAIN;
         default: state_n = IDLE;
      endcase
      // a word still owed by the ICache must be swallowed before refetching
      if (bus.if_flush) begin
         enq = 1'b0;
         ask_n = 1'b0;
         pred_n = 1'b0;
         pc_n = bus.addr_from_predictor;
         state_n = state == WAIT_INS || state == DRAIN ? DRAIN : IDLE;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         pc <= RESET_PC;
         ins_q <= '0;
         bus.ins_asked <= 1'b0;
         bus.ins_addr <= '0;
         bus.ask_predictor <= 1'b0;
         bus.ask_ins_addr <= '0;
         bus.jump_addr <= '0;
         bus.next_addr <= '0;
      end else if (rdy) begin
         state <= state_n;
         pc <= pc_n;
         ins_q <= ins_q_n;
         bus.ins_asked <= ask_n;
         bus.ins_addr <= ins_addr_n;
         bus.ask_predictor <= pred_n;
         bus.ask_ins_addr <= ask_ins_addr_n;
         bus.jump_addr <= jump_addr_n;
         bus.next_addr <= next_addr_n;
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         head <= '0;
         tail <= '0;
         count <= '0;
         bus.if_ins_launch_flag <= 1'b0;
         bus.if_ins <= '0;
         bus.if_ins_pc <= '0;
      end else if (rdy) begin
         head <= bus.if_flush ? '0 : head + PTR_W'(pop);
         tail <= bus.if_flush ? '0 : tail + PTR_W'(enq);
         count <= bus.if_flush ? '0 : count + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);
         bus.if_ins_launch_flag <= pop;
         if (pop) begin
            bus.if_ins <= mem_ins[head];
            bus.if_ins_pc <= mem_pc[head];
         end
      end
   always_ff @(posedge clk)
      if (rdy && enq) begin
         mem_ins[tail] <= enq_ins;
         mem_pc[tail] <= pc;
      end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb_instruction_fetch_queue: directed checks of fetch, next-PC decode, backpressure, flush and reset.
module tb_instruction_fetch_queue;
   logic clk, rst, rdy;
   int checks = 0, errors = 0, cyc = 0, mode = 0, ic_lat = 0;
   bit pred_hold = 0;
   logic [31:0] req[$], lpc[$], lins[$];
   int lcyc[$];
   logic [31:0] pa_ins, pa_jump, pa_next, a;
   int n0, l0;
   instruction_fetch_queue_if #(.PTR_W(3)) bus();
   instruction_fetch_queue dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));
   function automatic logic [31:0] imem(input logic [31:0] ad);
      if (mode == 1 && ad == 32'h10) return 32'h1000006F;
      if (mode == 2 && ad == 32'h20) return 32'hFE000CE3;
      if (mode == 3 && ad == 32'h30) return 32'h00008067;
      return {ad[11:0], 20'h00013};
   endfunction
   function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
      return i < q.size() ? q[i] : 32'hDEADBEEF;
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic do_reset(input int m, input bit full);
      @(negedge clk);
      rst = 1;
      mode = m;
      ic_lat = 0;
      pred_hold = 0;
      bus.rob_full = full;
      bus.if_flush = 0;
      bus.jalr_commit = 0;
      run(6);
      req.delete();
      lpc.delete();
      lins.delete();
      lcyc.delete();
      rst = 0;
   endtask
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   initial forever @(posedge clk) cyc++;
   // zero-wait ICache when ic_lat is 0, otherwise the word arrives ic_lat cycles later
   initial forever begin
      @(negedge clk);
      bus.ic_rdy = 0;
      if (bus.ins_asked) begin
         a = bus.ins_addr;
         repeat (ic_lat) @(negedge clk);
         bus.ic_rdy = 1;
         bus.ins = imem(a);
      end
   end
   initial forever begin
      @(negedge clk);
      bus.predictor_sgn_rdy = bus.ask_predictor && !pred_hold;
      bus.jump = 1;
   end
   initial forever begin
      @(negedge clk);
      if (bus.ins_asked) req.push_back(bus.ins_addr);
      if (bus.if_ins_launch_flag) begin
         lpc.push_back(bus.if_ins_pc);
         lins.push_back(bus.if_ins);
         lcyc.push_back(cyc);
      end
      if (bus.ask_predictor) begin
         pa_ins = bus.ask_ins_addr;
         pa_jump = bus.jump_addr;
         pa_next = bus.next_addr;
      end
   end
   initial begin
      rst = 1;
      rdy = 1;
      bus.ic_rdy = 0;
      bus.ins = 0;
      bus.jump = 0;
      bus.predictor_sgn_rdy = 0;
      bus.predictor_full = 0;
      bus.if_flush = 0;
      bus.addr_from_predictor = 0;
      bus.jalr_commit = 0;
      bus.jalr_addr = 0;
      bus.rob_full = 0;
      bus.lsb_full = 0;
      do_reset(0, 0);
      chk("reset_outs", bus.ins_addr | bus.if_ins | bus.if_ins_pc | bus.jump_addr, 0);
      chk("reset_pulses", {bus.ins_asked, bus.ask_predictor, bus.if_ins_launch_flag, bus.queue_count}, 0);
      run(30);
      chk("line_launches", lpc.size() >= 10, 1);
      for (int k = 0; k < 10; k++) chk($sformatf("line_pc%0d", k), at(lpc, k), 32'(4 * k));
      chk("line_ins9", at(lins, 9), imem(32'h24));
      do_reset(0, 1);
      run(24);
      chk("bp_count", 32'(bus.queue_count), 8);
      chk("bp_nolaunch", lpc.size(), 0);
      chk("bp_reqs", req.size(), 8);
      run(4);
      chk("bp_reqs_stop", req.size(), 8);
      rdy = 0;
      bus.rob_full = 0;
      run(3);
      chk("freeze_nolaunch", lpc.size(), 0);
      chk("freeze_count", 32'(bus.queue_count), 8);
      rdy = 1;
      run(12);
      chk("bp_release", lpc.size() >= 8, 1);
      chk("bp_b2b", lcyc.size() >= 8 ? lcyc[7] - lcyc[0] : -1, 7);
      chk("bp_pc7", at(lpc, 7), 32'h1C);
      chk("bp_resume", req.size() > 8, 1);
      do_reset(1, 0);
      run(20);
      chk("jal_req", at(req, 4), 32'h10);
      chk("jal_target", at(req, 5), 32'h110);
      chk("jal_launch", at(lpc, 5), 32'h110);
      do_reset(2, 0);
      run(40);
      chk("br_req", at(req, 8), 32'h20);
      chk("br_target", at(req, 9), 32'h18);
      chk("br_ask_pc", pa_ins, 32'h20);
      chk("br_jump_addr", pa_jump, 32'h18);
      chk("br_next_addr", pa_next, 32'h24);
      chk("br_launch_ins", at(lins, 8), 32'hFE000CE3);
      do_reset(3, 0);
      run(40);
      chk("jalr_req", at(req, 12), 32'h30);
      chk("jalr_stall", req.size(), 13);
      chk("jalr_launch", at(lpc, 12), 32'h30);
      bus.jalr_commit = 1;
      bus.jalr_addr = 32'h200;
      @(negedge clk);
      bus.jalr_commit = 0;
      run(5);
      chk("jalr_target", at(req, 13), 32'h200);
      do_reset(0, 1);
      run(10);
      ic_lat = 3;
      for (int i = 0; i < 10 && !bus.ins_asked; i++) @(negedge clk);
      chk("fl_waitins", bus.ins_asked, 1);
      bus.if_flush = 1;
      bus.addr_from_predictor = 32'h80;
      @(negedge clk);
      bus.if_flush = 0;
      chk("fl_count", 32'(bus.queue_count), 0);
      n0 = req.size();
      l0 = lpc.size();
      bus.rob_full = 0;
      run(15);
      chk("fl_req", at(req, n0), 32'h80);
      chk("fl_launch_pc", at(lpc, l0), 32'h80);
      chk("fl_launch_ins", at(lins, l0), imem(32'h80));
      do_reset(2, 0);
      pred_hold = 1;
      for (int i = 0; i < 40 && !bus.ask_predictor; i++) @(negedge clk);
      chk("ar_waitpred", bus.ask_predictor, 1);
      #2 rst = 1;
      #1;
      chk("ar_addrs", bus.ins_addr | bus.ask_ins_addr | bus.jump_addr | bus.next_addr | bus.if_ins | bus.if_ins_pc, 0);
      chk("ar_pulses", {bus.ins_asked, bus.ask_predictor, bus.if_ins_launch_flag, bus.queue_count}, 0);
      @(negedge clk);
      pred_hold = 0;
      n0 = req.size();
      rst = 0;
      run(4);
      chk("ar_first_fetch", at(req, n0), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
